decode_issue: RTL and testbench



---
 rtl/octa16_pkg.sv | 27 ++
 rtl/decode_issue_regfile.sv | 51 +++++
 rtl/decode_issue.sv | 121 ++++++++++++
 tb/tb_decode_issue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/octa16_pkg.sv
// Octa16 shared decode definitions: opcodes, instruction field positions and
// default datapath widths used by the decode/issue stage and its register file.
package octa16_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 3;

  localparam logic [2:0] OP_ADDSUB = 3'b000;
  localparam logic [2:0] OP_LOGIC  = 3'b001;
  localparam logic [2:0] OP_SLTU   = 3'b010;
  localparam logic [2:0] OP_SHIFT  = 3'b011;
  localparam logic [2:0] OP_SRA    = 3'b100;

  localparam int F_CTRL_LSB = 13;
  localparam int F_FLAG     = 12;
  localparam int F_RD_LSB   = 9;
  localparam int F_RS1_LSB  = 6;
  localparam int F_IMM_SEL  = 5;
  localparam int F_RS2_LSB  = 2;
  localparam int F_IMM_LSB  = 0;
  localparam int F_IMM_W    = 5;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SRA;
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// Register file for decode_issue: two combinational read ports with
// write-through bypass, one write port, r0 hardwired to zero.
module regfile
  import octa16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] w_regs [NREG];
  logic              w_byp1;
  logic              w_byp2;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_q <= '0;
          end else if (i_we && i_waddr == REG_AW'(gi)) begin
            r_q <= i_wdata;
          end
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  // Bypass never applies to r0 so a writeback aimed at r0 cannot leak a value.
  assign w_byp1   = i_we && (i_waddr == i_raddr1) && (i_raddr1 != '0);
  assign w_byp2   = i_we && (i_waddr == i_raddr2) && (i_raddr2 != '0);
  assign o_rdata1 = w_byp1 ? i_wdata : w_regs[i_raddr1];
  assign o_rdata2 = w_byp2 ? i_wdata : w_regs[i_raddr2];

endmodule

// File: rtl/decode_issue.sv
// Octa16 decode/operand-issue stage: decodes 16-bit instructions, reads operands,
// stalls on pending-register hazards and holds one registered op for the ALU.
module decode_issue
  import octa16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_rs1,
  output logic [DATA_W-1:0] ex_rs2,
  output logic [2:0]        ex_ctrl,
  output logic              ex_flag,
  output logic [REG_AW-1:0] ex_rd,
  output logic              illegal
);

  localparam int NREG = 2 ** REG_AW;

  logic              w_legal;
  logic [2:0]        w_ctrl;
  logic              w_flag;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_imm_sel;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [NREG-1:0]   w_clear;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_busy;
  logic              w_hazard;
  logic              w_ready;
  logic              w_accept;

  logic [NREG-1:0]   r_pending;
  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_rs1;
  logic [DATA_W-1:0] r_ex_rs2;
  logic [2:0]        r_ex_ctrl;
  logic              r_ex_flag;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_illegal;

  // Illegal ops are squashed here into ADD r0+r0 -> r0, so they never stall or mark pending.
  assign w_legal   = op_legal(instr[F_CTRL_LSB +: 3]);
  assign w_ctrl    = w_legal ? instr[F_CTRL_LSB +: 3] : OP_ADDSUB;
  assign w_flag    = w_legal & instr[F_FLAG];
  assign w_rd      = w_legal ? instr[F_RD_LSB +: REG_AW]  : '0;
  assign w_rs1     = w_legal ? instr[F_RS1_LSB +: REG_AW] : '0;
  assign w_rs2     = w_legal ? instr[F_RS2_LSB +: REG_AW] : '0;
  assign w_imm_sel = w_legal & instr[F_IMM_SEL];
  assign w_imm     = {{(DATA_W-F_IMM_W){instr[F_IMM_LSB+F_IMM_W-1]}},
                      instr[F_IMM_LSB +: F_IMM_W]};

  regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (wb_en),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // A register being written back this cycle no longer blocks issue.
  assign w_clear  = wb_en ? (NREG'(1) << wb_rd) : '0;
  assign w_busy   = r_pending & ~w_clear;
  assign w_hazard = w_busy[w_rs1] | (!w_imm_sel & w_busy[w_rs2]) | w_busy[w_rd];
  assign w_ready  = (!r_ex_valid || ex_ready) && !w_hazard;
  assign w_accept = instr_valid && w_ready;
  assign w_set    = (w_accept && w_rd != '0) ? (NREG'(1) << w_rd) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_ex_valid <= 1'b0;
      r_ex_rs1   <= '0;
      r_ex_rs2   <= '0;
      r_ex_ctrl  <= '0;
      r_ex_flag  <= 1'b0;
      r_ex_rd    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_pending <= ((r_pending & ~w_clear) | w_set) & ~NREG'(1);
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        r_ex_valid <= 1'b1;
        r_ex_rs1   <= w_rdata1;
        r_ex_rs2   <= w_imm_sel ? w_imm : w_rdata2;
        r_ex_ctrl  <= w_ctrl;
        r_ex_flag  <= w_flag;
        r_ex_rd    <= w_rd;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign instr_ready = w_ready;
  assign ex_valid    = r_ex_valid;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign ex_ctrl     = r_ex_ctrl;
  assign ex_flag     = r_ex_flag;
  assign ex_rd       = r_ex_rd;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios followed by random
// traffic, all compared against an array-based model of the stage's rules.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [7:0]  ex_rs1;
  logic [7:0]  ex_rs2;
  logic [2:0]  ex_ctrl;
  logic        ex_flag;
  logic [2:0]  ex_rd;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  logic obs_ready;

  // Reference model state
  logic [7:0] m_regs [8];
  bit         m_pend [8];
  bit         m_vld;
  bit         m_ill;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [2:0] m_ctrl;
  logic [2:0] m_rd;
  logic       m_flag;

  always #5 clk = ~clk;

  decode_issue #(.DATA_W(8), .REG_AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_ctrl     (ex_ctrl),
    .ex_flag     (ex_flag),
    .ex_rd       (ex_rd),
    .illegal     (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int ctrl, input int flag, input int rd,
                                      input int rs1, input int isel, input int low5);
    return {3'(ctrl), 1'(flag), 3'(rd), 3'(rs1), 1'(isel), 5'(low5)};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_regs[r] = 8'h00;
      m_pend[r] = 1'b0;
    end
    m_vld = 0; m_ill = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_flag = 0;
  endtask

  function automatic bit busy(input int src, input bit we, input int wr);
    return src != 0 && m_pend[src] && !(we && wr == src);
  endfunction

  function automatic logic [7:0] rd_val(input int src, input bit we, input int wr, input int wd);
    if (src == 0) return 8'h00;
    if (we && wr == src) return 8'(wd);
    return m_regs[src];
  endfunction

  // One clock of stimulus: drive, check ready mid-cycle, clock, advance model, check outputs.
  task automatic step(input bit v, input logic [15:0] ins, input bit we, input int wr,
                      input int wd, input bit er, input string tag);
    int op, fl, d, s1, s2, isel, imm;
    bit bad, hz, exp_ready, acc;
    logic [7:0] a, b;
    instr_valid = v; instr = ins; wb_en = we; wb_rd = 3'(wr); wb_data = 8'(wd); ex_ready = er;
    @(negedge clk);
    obs_ready = instr_ready;
    op = int'(ins[15:13]); fl = int'(ins[12]); d = int'(ins[11:9]); s1 = int'(ins[8:6]);
    isel = int'(ins[5]); s2 = int'(ins[4:2]); imm = int'(ins[4:0]);
    if (imm >= 16) imm -= 32;
    bad = op > 4;
    if (bad) begin
      op = 0; fl = 0; d = 0; s1 = 0; s2 = 0; isel = 0;
    end
    hz = busy(s1, we, wr) || (isel == 0 && busy(s2, we, wr)) || busy(d, we, wr);
    exp_ready = (!m_vld || er) && !hz;
    check({tag, ".ready"}, obs_ready, exp_ready);
    acc = v && exp_ready;
    a = rd_val(s1, we, wr, wd);
    b = isel ? 8'(imm) : rd_val(s2, we, wr, wd);
    @(posedge clk);
    #1;
    if (acc) begin
      m_vld = 1; m_a = a; m_b = b; m_ctrl = 3'(op); m_flag = 1'(fl); m_rd = 3'(d);
    end else if (er) begin
      m_vld = 0;
    end
    m_ill = acc && bad;
    if (we && wr != 0) m_regs[wr] = 8'(wd);
    if (we) m_pend[wr] = 0;
    if (acc && d != 0) m_pend[d] = 1;
    check({tag, ".ex_valid"}, ex_valid, m_vld);
    check({tag, ".illegal"}, illegal, m_ill);
    if (m_vld) begin
      check({tag, ".ex_rs1"}, ex_rs1, m_a);
      check({tag, ".ex_rs2"}, ex_rs2, m_b);
      check({tag, ".ex_ctrl"}, ex_ctrl, m_ctrl);
      check({tag, ".ex_flag"}, ex_flag, m_flag);
      check({tag, ".ex_rd"}, ex_rd, m_rd);
    end
  endtask

  initial begin
    int wr;
    int q[$];
    rst = 1'b1; instr_valid = 0; instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check("rst.ex_valid", ex_valid, 1'b0);
    check("rst.ex_rs1", ex_rs1, 8'h00);
    check("rst.ex_rs2", ex_rs2, 8'h00);
    check("rst.ex_ctrl", ex_ctrl, 3'd0);
    check("rst.ex_flag", ex_flag, 1'b0);
    check("rst.ex_rd", ex_rd, 3'd0);
    check("rst.illegal", illegal, 1'b0);

    // ADD r1 <- r0 + 5
    step(1, enc(0, 0, 1, 0, 1, 5), 0, 0, 0, 1, "imm5");
    check("imm5.rs2_const", ex_rs2, 8'h05);
    check("imm5.rd_const", ex_rd, 3'd1);
    step(1, enc(0, 0, 2, 1, 1, 0), 0, 0, 0, 1, "pend1");
    check("pend1.stall", obs_ready, 1'b0);
    step(0, 16'h0000, 1, 1, 8'h11, 1, "clr1");

    step(1, enc(0, 0, 4, 0, 1, 5'b11100), 0, 0, 0, 1, "negimm");
    check("negimm.rs2_const", ex_rs2, 8'hFC);

    // RAW on r2 resolved by same-cycle writeback with bypass
    step(1, enc(0, 0, 2, 0, 1, 1), 1, 4, 8'h44, 1, "raw.iss");
    step(1, enc(0, 0, 5, 2, 1, 0), 0, 0, 0, 1, "raw.stall");
    check("raw.stall_const", obs_ready, 1'b0);
    step(1, enc(0, 0, 5, 2, 1, 0), 1, 2, 8'h3C, 1, "raw.byp");
    check("raw.ready_const", obs_ready, 1'b1);
    check("raw.rs1_const", ex_rs1, 8'h3C);

    // Backpressure: held op stays, then consumed and replaced with no bubble
    for (int k = 0; k < 3; k++) begin
      step(1, enc(1, 1, 6, 0, 1, 3), 0, 0, 0, 0, "bp.hold");
      check("bp.hold_ready", obs_ready, 1'b0);
      check("bp.hold_rd", ex_rd, 3'd5);
      check("bp.hold_rs1", ex_rs1, 8'h3C);
    end
    step(1, enc(1, 1, 6, 0, 1, 3), 0, 0, 0, 1, "bp.go");
    check("bp.go_valid", ex_valid, 1'b1);
    check("bp.go_rd", ex_rd, 3'd6);
    check("bp.go_ctrl", ex_ctrl, 3'd1);

    // Illegal ctrl=110
    step(1, enc(6, 1, 7, 3, 0, 12), 0, 0, 0, 1, "ill");
    check("ill.pulse", illegal, 1'b1);
    check("ill.ctrl", ex_ctrl, 3'd0);
    check("ill.rs1", ex_rs1, 8'h00);
    check("ill.rs2", ex_rs2, 8'h00);
    check("ill.rd", ex_rd, 3'd0);
    step(1, enc(0, 0, 1, 7, 1, 0), 1, 6, 0, 1, "ill.after");
    check("ill.one_cycle", illegal, 1'b0);
    check("ill.no_pend7", obs_ready, 1'b1);

    // Asynchronous reset while an op is held and r3 is pending
    step(0, 16'h0000, 1, 3, 8'h77, 1, "ar.wr3");
    step(1, enc(0, 0, 3, 0, 1, 2), 0, 0, 0, 1, "ar.iss");
    step(0, 16'h0000, 0, 0, 0, 0, "ar.hold");
    instr_valid = 0;
    rst = 1'b1;
    #2;
    check("ar.ex_valid", ex_valid, 1'b0);
    check("ar.ex_rd", ex_rd, 3'd0);
    check("ar.ex_rs2", ex_rs2, 8'h00);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, enc(0, 0, 0, 3, 0, 12), 0, 0, 0, 1, "ar.read3");
    check("ar.r3_ready", obs_ready, 1'b1);
    check("ar.r3_zero", ex_rs1, 8'h00);

    // Random traffic, writebacks biased toward pending registers
    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 9) < 7) wr = q[$urandom_range(0, q.size() - 1)];
      else wr = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1, wr,
           $urandom_range(0, 255), $urandom_range(0, 3) != 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
